// File: rtl/wb_regfile.sv
// Writeback select plus 32x32 architectural register file with two combinational read ports and a commit counter.
// Optional REGFILE_BYPASS_EN: same-cycle write-through from the writeback value to the read ports.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_regWrite_mem_wb,
  input  logic              ctrl_memToReg_mem_wb,
  input  logic [DATA_W-1:0] read_data_from_mem_mem_wb,
  input  logic [DATA_W-1:0] alu_result_mem_wb,
  input  logic [ADDR_W-1:0] write_register_mem_wb,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] write_data_wb,
  output logic [31:0]       wb_commit_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [31:0]       commit_cnt;
  logic              commit;

  assign write_data_wb = ctrl_memToReg_mem_wb ? read_data_from_mem_mem_wb : alu_result_mem_wb;

  // An X on the enable must never look like a write, hence the case-equality test.
  assign commit = (ctrl_regWrite_mem_wb === 1'b1) && (write_register_mem_wb != '0) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      commit_cnt <= '0;
    end else if (commit) begin
      regs[write_register_mem_wb] <= write_data_wb;
      commit_cnt                  <= commit_cnt + 32'd1;
    end
  end

  assign wb_commit_count = commit_cnt;

  always_comb begin
    read_data_1 = (read_register_1 == '0) ? '0 : regs[read_register_1];
    read_data_2 = (read_register_2 == '0) ? '0 : regs[read_register_2];
`ifdef REGFILE_BYPASS_EN
    // commit already excludes $0 and reset, so the bypass never exposes a dropped write.
    if (commit && (write_register_mem_wb == read_register_1)) begin
      read_data_1 = write_data_wb;
    end
    if (commit && (write_register_mem_wb == read_register_2)) begin
      read_data_2 = write_data_wb;
    end
`endif
  end

endmodule
